// File: rtl/pipe_stage_ctrl_pkg.sv
// Shared definitions for the pipeline controller and the hazard unit.
package pipe_stage_ctrl_pkg;

    localparam int PIPE_MAX_STAGES    = 16;
    localparam int PIPE_CNT_W_DEFAULT = 32;

    // Boundary i dies when any stage at or older than i squashes; this is the
    // prefix-OR of the effective squash vector taken from the oldest end.
    function automatic logic [PIPE_MAX_STAGES-1:0] pipe_kill_prefix(
        input logic [PIPE_MAX_STAGES-1:0] sq_eff
    );
        logic [PIPE_MAX_STAGES-1:0] kill;
        logic                       acc;
        acc  = 1'b0;
        kill = '0;
        for (int k = PIPE_MAX_STAGES-1; k >= 0; k--) begin
            acc     = acc | sq_eff[k];
            kill[k] = acc;
        end
        return kill;
    endfunction

endpackage

// File: rtl/pipe_stall_counter.sv
// Saturating event counter with synchronous clear; counts stalled cycles.
module pipe_stall_counter
    import pipe_stage_ctrl_pkg::*;
#(
    parameter int CNT_W = PIPE_CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Clear wins over increment; reset behaves like a clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= sat_inc(count);
        end
    end

endmodule

// File: rtl/pipe_stage_ctrl.sv
// Per-boundary enable/squash generator for an in-order pipeline.
// Stage 0 is the youngest (fetch), stage NUM_STAGES-1 the oldest.
module pipe_stage_ctrl
    import pipe_stage_ctrl_pkg::*;
#(
    parameter int NUM_STAGES = 5,
    parameter int CNT_W      = PIPE_CNT_W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NUM_STAGES-1:0] stall_req,
    input  logic [NUM_STAGES-1:0] squash_req,
    output logic [NUM_STAGES-1:0] en,
    output logic [NUM_STAGES-1:0] squashn,
    output logic [NUM_STAGES-1:0] valid,
    output logic [NUM_STAGES-1:0] stalled,
    output logic                  retire,
    input  logic                  cnt_clr,
    output logic [CNT_W-1:0]      stall_cycles
);

    logic [NUM_STAGES-1:0]      stall_chain;
    logic [NUM_STAGES-1:0]      sq_eff;
    logic [NUM_STAGES-1:0]      kill;
    logic [PIPE_MAX_STAGES-1:0] sq_pad;
    logic [NUM_STAGES-1:0]      up_valid;
    logic [NUM_STAGES-1:0]      up_adv;
    logic [NUM_STAGES-1:0]      valid_next;

    // Backward stall propagation: a live stage holds if it asks to or the
    // stage ahead of it holds; an empty stage absorbs the stall.
    always_comb begin
        logic older;
        older       = 1'b0;
        stall_chain = '0;
        for (int i = NUM_STAGES-1; i >= 0; i--) begin
            stall_chain[i] = valid[i] & (stall_req[i] | older);
            older          = stall_chain[i];
        end
    end

    // Redirects count only from live stages on the cycle they advance.
    always_comb begin
        sq_eff                    = squash_req & valid & ~stall_chain;
        sq_pad                    = '0;
        sq_pad[NUM_STAGES-1:0]    = sq_eff;
        kill                      = NUM_STAGES'(pipe_kill_prefix(sq_pad));
    end

    // What feeds each boundary: fetch for boundary 0, otherwise the next
    // younger stage, which only hands over when it is live and moving.
    generate
        for (genvar g = 0; g < NUM_STAGES; g++) begin : g_bnd
            if (g == 0) begin : g_src_fetch
                assign up_valid[g] = in_valid;
                assign up_adv[g]   = in_valid;
            end else begin : g_src_stage
                assign up_valid[g] = valid[g-1];
                assign up_adv[g]   = valid[g-1] & ~stall_chain[g-1];
            end
            // Clear on reset, on kill, or when an advancing stage has nothing
            // arriving (bubble); clear overrides the load enable.
            assign squashn[g] = ~reset & ~kill[g] & (stall_chain[g] | up_adv[g]);
        end
    endgenerate

    assign en       = reset ? '0 : ~stall_chain;
    assign stalled  = reset ? '0 : stall_chain;
    assign in_ready = ~reset & ~stall_chain[0];
    assign retire   = ~reset & valid[NUM_STAGES-1] & ~stall_chain[NUM_STAGES-1];

    // Valid bits follow exactly what the pipeline registers will hold.
    always_comb begin
        valid_next = valid;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (!squashn[i]) begin
                valid_next[i] = 1'b0;
            end else if (!stall_chain[i]) begin
                valid_next[i] = up_valid[i];
            end
        end
    end

    // Valid registers; reset empties the whole pipe.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= '0;
        end else begin
            valid <= valid_next;
        end
    end

    pipe_stall_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (|stalled),
        .count (stall_cycles)
    );

endmodule
